// File: rtl/debug_host_link.sv
// Host side of the MIPS debug-unit UART link: program load, step/continue, dump capture.
// Optional receive timeout in RX_DUMP is enabled with `define DEBUG_HOST_TIMEOUT_EN.

module tx_uart #(
    parameter int unsigned N_BITS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              tx_start,
    input  logic [N_BITS-1:0] din,
    output logic              tx,
    output logic              tx_done_tick
);
    localparam int unsigned NW = $clog2(N_BITS);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

    tx_state_e         state_q, state_d;
    logic [3:0]        s_q, s_d;
    logic [NW-1:0]     n_q, n_d;
    logic [N_BITS-1:0] b_q, b_d;
    logic              tx_q, tx_d, done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        done_d  = 1'b0;
        case (state_q)
            TX_IDLE: if (tx_start) begin
                state_d = TX_START;
                s_d     = '0;
                b_d     = din;
            end
            TX_START: if (tick) begin
                if (s_q == 4'd15) begin
                    state_d = TX_DATA;
                    s_d     = '0;
                    n_d     = '0;
                end else s_d = s_q + 4'd1;
            end
            TX_DATA: if (tick) begin
                if (s_q == 4'd15) begin
                    s_d = '0;
                    b_d = b_q >> 1;
                    if (n_q == NW'(N_BITS - 1)) state_d = TX_STOP;
                    else                        n_d = n_q + NW'(1);
                end else s_d = s_q + 4'd1;
            end
            TX_STOP: if (tick) begin
                if (s_q == 4'd15) begin
                    state_d = TX_IDLE;
                    done_d  = 1'b1;
                end else s_d = s_q + 4'd1;
            end
            default: state_d = TX_IDLE;
        endcase
        case (state_d)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = b_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    assign tx           = tx_q;
    assign tx_done_tick = done_q;
endmodule

module rx_uart #(
    parameter int unsigned N_BITS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              rx,
    output logic [N_BITS-1:0] dout,
    output logic              rx_done_tick
);
    localparam int unsigned NW = $clog2(N_BITS);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    rx_state_e         state_q, state_d;
    logic [1:0]        sync_q;
    logic [3:0]        s_q, s_d;
    logic [NW-1:0]     n_q, n_d;
    logic [N_BITS-1:0] b_q, b_d;
    logic              done_q, done_d;
    logic              rx_s;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
            sync_q  <= 2'b11;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], rx};
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            done_q  <= done_d;
        end
    end

    // Start bit is sampled at mid-bit (8 ticks), data bits every 16 ticks after that.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        done_d  = 1'b0;
        case (state_q)
            RX_IDLE: if (!rx_s) begin
                state_d = RX_START;
                s_d     = '0;
            end
            RX_START: if (tick) begin
                if (s_q == 4'd7) begin
                    state_d = RX_DATA;
                    s_d     = '0;
                    n_d     = '0;
                end else s_d = s_q + 4'd1;
            end
            RX_DATA: if (tick) begin
                if (s_q == 4'd15) begin
                    s_d = '0;
                    b_d = {rx_s, b_q[N_BITS-1:1]};
                    if (n_q == NW'(N_BITS - 1)) state_d = RX_STOP;
                    else                        n_d = n_q + NW'(1);
                end else s_d = s_q + 4'd1;
            end
            RX_STOP: if (tick) begin
                if (s_q == 4'd15) begin
                    state_d = RX_IDLE;
                    done_d  = 1'b1;
                end else s_d = s_q + 4'd1;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign dout         = b_q;
    assign rx_done_tick = done_q;
endmodule

module debug_host_link #(
    parameter int unsigned NB_DATA       = 32,
    parameter int unsigned N_BITS        = 8,
    parameter int unsigned N_BYTES       = 4,
    parameter int unsigned N_REGISTER    = 32,
    parameter int unsigned N_MEMORY_DATA = 127,
    parameter int unsigned NB_PADDR      = 7,
    parameter int unsigned TIMEOUT_TICKS = 32768
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                tick,
    input  logic                rx_i,
    output logic                tx_o,
    input  logic                load_i,
    input  logic                step_i,
    input  logic                cont_i,
    input  logic [NB_PADDR-1:0] prog_len_i,
    output logic [NB_PADDR-1:0] prog_addr_o,
    input  logic [NB_DATA-1:0]  prog_data_i,
    output logic                dump_we_o,
    output logic [7:0]          dump_addr_o,
    output logic [NB_DATA-1:0]  dump_data_o,
    output logic                busy_o,
    output logic                ready_o,
    output logic                done_o,
    output logic                err_o
);
    localparam int unsigned BC_W     = $clog2(N_BYTES + 1);
    localparam int unsigned LANE_W   = $clog2(N_BYTES);
    localparam int unsigned LAST_IDX = N_REGISTER + N_MEMORY_DATA - 1;

    typedef enum logic [2:0] {
        IDLE, FETCH, SEND_WORD, SEND_TERM, READY, SEND_MODE, RX_DUMP
    } state_e;

    state_e              state_q, state_d;
    logic [NB_PADDR-1:0] prog_addr_q, prog_addr_d, prog_len_q, prog_len_d;
    logic [NB_DATA-1:0]  word_q, word_d, dump_data_q, dump_data_d;
    logic [BC_W-1:0]     byte_cnt_q, byte_cnt_d;
    logic [N_BITS-1:0]   mode_q, mode_d;
    logic [7:0]          dump_addr_q, dump_addr_d;
    logic                fetch_wait_q, fetch_wait_d;
    logic                tx_idle_q, tx_idle_d, tx_done_prev_q;
    logic                dump_we_q, dump_we_d, busy_q, busy_d, ready_q, ready_d;
    logic                done_q, done_d, err_q, err_d;
    logic                tx_start_c, tx_done_tick, rx_done_tick;
    logic [N_BITS-1:0]   tx_din_c, rx_dout;
    logic [LANE_W-1:0]   lane;

`ifdef DEBUG_HOST_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_TICKS + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`else
    logic unused_tmo_c;
    assign unused_tmo_c = ^TIMEOUT_TICKS;
`endif

    assign lane = byte_cnt_q[LANE_W-1:0];

    tx_uart #(.N_BITS(N_BITS)) u_tx (
        .clk(clock_i), .rst_n(reset_i), .tick(tick), .tx_start(tx_start_c),
        .din(tx_din_c), .tx(tx_o), .tx_done_tick(tx_done_tick)
    );

    rx_uart #(.N_BITS(N_BITS)) u_rx (
        .clk(clock_i), .rst_n(reset_i), .tick(tick), .rx(rx_i),
        .dout(rx_dout), .rx_done_tick(rx_done_tick)
    );

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q        <= IDLE;
            prog_addr_q    <= '0;
            prog_len_q     <= '0;
            word_q         <= '0;
            byte_cnt_q     <= '0;
            mode_q         <= '0;
            fetch_wait_q   <= 1'b0;
            tx_idle_q      <= 1'b1;
            tx_done_prev_q <= 1'b0;
            dump_we_q      <= 1'b0;
            dump_addr_q    <= '0;
            dump_data_q    <= '0;
            busy_q         <= 1'b0;
            ready_q        <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
`ifdef DEBUG_HOST_TIMEOUT_EN
            tmo_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            prog_addr_q    <= prog_addr_d;
            prog_len_q     <= prog_len_d;
            word_q         <= word_d;
            byte_cnt_q     <= byte_cnt_d;
            mode_q         <= mode_d;
            fetch_wait_q   <= fetch_wait_d;
            tx_idle_q      <= tx_idle_d;
            tx_done_prev_q <= tx_done_tick;
            dump_we_q      <= dump_we_d;
            dump_addr_q    <= dump_addr_d;
            dump_data_q    <= dump_data_d;
            busy_q         <= busy_d;
            ready_q        <= ready_d;
            done_q         <= done_d;
            err_q          <= err_d;
`ifdef DEBUG_HOST_TIMEOUT_EN
            tmo_q          <= tmo_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        prog_addr_d  = prog_addr_q;
        prog_len_d   = prog_len_q;
        word_d       = word_q;
        byte_cnt_d   = byte_cnt_q;
        mode_d       = mode_q;
        fetch_wait_d = fetch_wait_q;
        dump_we_d    = 1'b0;
        dump_addr_d  = dump_addr_q;
        dump_data_d  = dump_data_q;
        done_d       = 1'b0;
        err_d        = err_q;
        tx_start_c   = 1'b0;
        tx_din_c     = word_q[lane*N_BITS +: N_BITS];
        tx_idle_d    = tx_idle_q | (tx_done_tick & ~tx_done_prev_q);
`ifdef DEBUG_HOST_TIMEOUT_EN
        tmo_d        = '0;
`endif
        case (state_q)
            IDLE, READY: begin
                if (load_i) begin
                    prog_len_d   = prog_len_i;
                    prog_addr_d  = '0;
                    fetch_wait_d = 1'b0;
                    err_d        = 1'b0;
                    state_d      = FETCH;
                end else if (state_q == READY && (step_i || cont_i)) begin
                    mode_d     = step_i ? N_BITS'(8'h01) : N_BITS'(8'h02);
                    byte_cnt_d = '0;
                    state_d    = SEND_MODE;
                end
            end
            // ROM data is valid on the second cycle in FETCH.
            FETCH: begin
                fetch_wait_d = ~fetch_wait_q;
                if (fetch_wait_q) begin
                    word_d     = prog_data_i;
                    byte_cnt_d = '0;
                    if (prog_data_i == {NB_DATA{1'b1}}) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = SEND_WORD;
                    end
                end
            end
            // The next fetch overlaps transmission of the last byte of the word.
            SEND_WORD: if (tx_idle_q) begin
                tx_start_c = 1'b1;
                byte_cnt_d = byte_cnt_q + BC_W'(1);
                if (byte_cnt_q == BC_W'(N_BYTES - 1)) begin
                    byte_cnt_d = '0;
                    if (prog_addr_q == prog_len_q - NB_PADDR'(1)) begin
                        state_d = SEND_TERM;
                    end else begin
                        prog_addr_d = prog_addr_q + NB_PADDR'(1);
                        state_d     = FETCH;
                    end
                end
            end
            SEND_TERM: if (tx_idle_q) begin
                if (byte_cnt_q == BC_W'(N_BYTES)) begin
                    done_d  = 1'b1;
                    state_d = READY;
                end else begin
                    tx_start_c = 1'b1;
                    tx_din_c   = '1;
                    byte_cnt_d = byte_cnt_q + BC_W'(1);
                end
            end
            SEND_MODE: if (tx_idle_q) begin
                if (byte_cnt_q == '0) begin
                    tx_start_c = 1'b1;
                    tx_din_c   = mode_q;
                    byte_cnt_d = BC_W'(1);
                end else if (mode_q == N_BITS'(8'h01)) begin
                    dump_addr_d = '0;
                    byte_cnt_d  = '0;
                    word_d      = '0;
                    state_d     = RX_DUMP;
                end else begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            RX_DUMP: begin
                if (dump_we_q) begin
                    if (dump_addr_q == 8'(LAST_IDX)) begin
                        done_d  = 1'b1;
                        state_d = READY;
                    end else begin
                        dump_addr_d = dump_addr_q + 8'd1;
                    end
                end
                if (rx_done_tick) begin
                    word_d[lane*N_BITS +: N_BITS] = rx_dout;
                    byte_cnt_d = byte_cnt_q + BC_W'(1);
                    if (byte_cnt_q == BC_W'(N_BYTES - 1)) begin
                        byte_cnt_d  = '0;
                        dump_we_d   = 1'b1;
                        dump_data_d = word_d;
                    end
                end
`ifdef DEBUG_HOST_TIMEOUT_EN
                tmo_d = tmo_q;
                if (rx_done_tick) begin
                    tmo_d = '0;
                end else if (tick) begin
                    if (tmo_q == TMO_W'(TIMEOUT_TICKS - 1)) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        if (tx_start_c) tx_idle_d = 1'b0;
        busy_d  = !(state_d == IDLE || state_d == READY);
        ready_d = (state_d == READY);
    end

    assign prog_addr_o = prog_addr_q;
    assign dump_we_o   = dump_we_q;
    assign dump_addr_o = dump_addr_q;
    assign dump_data_o = dump_data_q;
    assign busy_o      = busy_q;
    assign ready_o     = ready_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
endmodule

// File: tb/tb_debug_host_link.sv
// Bench for debug_host_link: serial decoder on tx_o, debug-unit byte model on rx_i.
module tb_debug_host_link;
    // Memory depth and timeout shortened so a full dump fits a short run.
    localparam int unsigned N_MEM   = 7;
    localparam int unsigned TMO     = 2048;
    localparam int unsigned N_WORDS = 32 + N_MEM;

    logic        clock_i = 1'b0;
    logic        reset_i, tick, rx_i, load_i, step_i, cont_i;
    logic [6:0]  prog_len_i, prog_addr_o;
    logic [31:0] prog_data_i, dump_data_o;
    logic        tx_o, dump_we_o, busy_o, ready_o, done_o, err_o;
    logic [7:0]  dump_addr_o;

    always #5 clock_i = ~clock_i;

    debug_host_link #(.N_MEMORY_DATA(N_MEM), .TIMEOUT_TICKS(TMO)) dut (
        .clock_i(clock_i), .reset_i(reset_i), .tick(tick), .rx_i(rx_i), .tx_o(tx_o),
        .load_i(load_i), .step_i(step_i), .cont_i(cont_i), .prog_len_i(prog_len_i),
        .prog_addr_o(prog_addr_o), .prog_data_i(prog_data_i), .dump_we_o(dump_we_o),
        .dump_addr_o(dump_addr_o), .dump_data_o(dump_data_o), .busy_o(busy_o),
        .ready_o(ready_o), .done_o(done_o), .err_o(err_o)
    );

    logic [31:0] rom [128];
    always @(posedge clock_i) prog_data_i <= rom[prog_addr_o];

    int checks = 0, errors = 0;
    int cyc = 0;
    always @(posedge clock_i) cyc <= cyc + 1;

    // Serial decoder: samples tx_o mid-bit (16 cycles per bit, tick held high).
    logic [7:0] txb [$];
    logic [7:0] dec_b;
    initial begin
        forever begin
            @(negedge clock_i);
            if (reset_i === 1'b1 && tx_o === 1'b0) begin
                repeat (8) @(negedge clock_i);
                for (int i = 0; i < 8; i++) begin
                    repeat (16) @(negedge clock_i);
                    dec_b[i] = tx_o;
                end
                repeat (16) @(negedge clock_i);
                txb.push_back(dec_b);
            end
        end
    end

    int we_cnt = 0, we_base = 0, bad_words = 0, done_cnt = 0;
    int last_we_cyc = 0, last_done_cyc = 0;
    logic [7:0]  last_addr = '0;
    logic [31:0] last_data = '0;
    always @(negedge clock_i) begin
        if (dump_we_o) begin
            if (dump_addr_o != 8'(we_cnt - we_base) ||
                dump_data_o != 32'hA500_0000 + 32'(dump_addr_o))
                bad_words <= bad_words + 1;
            we_cnt      <= we_cnt + 1;
            last_addr   <= dump_addr_o;
            last_data   <= dump_data_o;
            last_we_cyc <= cyc;
        end
        if (done_o) begin
            done_cnt      <= done_cnt + 1;
            last_done_cyc <= cyc;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_i = 1'b0;
        repeat (16) @(negedge clock_i);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (16) @(negedge clock_i);
        end
        rx_i = 1'b1;
        repeat (16) @(negedge clock_i);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic pulse(input int which);
        @(negedge clock_i);
        if (which == 0) load_i = 1'b1; else if (which == 1) step_i = 1'b1; else cont_i = 1'b1;
        @(negedge clock_i);
        load_i = 1'b0; step_i = 1'b0; cont_i = 1'b0;
    endtask

    task automatic wait_not_busy(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clock_i);
            if (!busy_o) ok = 1'b1;
        end
    endtask

    task automatic wait_bytes(input int n, input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clock_i);
            if (txb.size() >= n) ok = 1'b1;
        end
    endtask

    task automatic load_spec_prog();
        logic ok;
        rom[0] = 32'h2001_0005; rom[1] = 32'h2002_0003; rom[2] = 32'h0022_1820;
        prog_len_i = 7'd3;
        pulse(0);
        wait_not_busy(20000, ok);
        repeat (200) @(negedge clock_i);
        check("reload.ready", 32'(ready_o), 32'd1);
        txb.delete();
    endtask

    typedef struct {
        logic [6:0]  len;
        logic [31:0] w [3];
        int          exp_words;
        logic        exp_err;
        logic        exp_ready;
    } load_vec_t;

    load_vec_t   vecs [4];
    logic [7:0]  exp_b [$];
    logic        ok;
    int          d0, w0, bw0;
    logic [31:0] wexp;

    initial begin
        vecs[0] = '{len: 7'd1, w: '{32'hFFFF_FFFF, 32'h0, 32'h0}, exp_words: 0, exp_err: 1'b1, exp_ready: 1'b0};
        vecs[1] = '{len: 7'd3, w: '{32'h2001_0005, 32'hFFFF_FFFF, 32'h0}, exp_words: 1, exp_err: 1'b1, exp_ready: 1'b0};
        vecs[2] = '{len: 7'd1, w: '{32'h1234_5678, 32'h0, 32'h0}, exp_words: 1, exp_err: 1'b0, exp_ready: 1'b1};
        vecs[3] = '{len: 7'd3, w: '{32'h2001_0005, 32'h2002_0003, 32'h0022_1820}, exp_words: 3, exp_err: 1'b0, exp_ready: 1'b1};
        for (int i = 0; i < 128; i++) rom[i] = 32'h0;

        reset_i = 1'b0; tick = 1'b1; rx_i = 1'b1;
        load_i = 1'b0; step_i = 1'b0; cont_i = 1'b0; prog_len_i = 7'd0;
        repeat (3) @(negedge clock_i);
        check("rst.tx_o", 32'(tx_o), 32'd1);
        check("rst.flags", {27'd0, busy_o, ready_o, done_o, err_o, dump_we_o}, 32'd0);
        check("rst.dump_addr", 32'(dump_addr_o), 32'd0);
        check("rst.dump_data", dump_data_o, 32'd0);
        check("rst.prog_addr", 32'(prog_addr_o), 32'd0);
        reset_i = 1'b1;

        // Commands in IDLE are ignored.
        pulse(1); pulse(2);
        repeat (300) @(negedge clock_i);
        check("idle_cmd.bytes", 32'(txb.size()), 32'd0);
        check("idle_cmd.busy", 32'(busy_o), 32'd0);

        for (int v = 0; v < 4; v++) begin
            for (int k = 0; k < 3; k++) rom[k] = vecs[v].w[k];
            prog_len_i = vecs[v].len;
            exp_b.delete();
            for (int k = 0; k < vecs[v].exp_words; k++)
                for (int j = 0; j < 4; j++) exp_b.push_back(vecs[v].w[k][8*j +: 8]);
            if (vecs[v].exp_ready) for (int j = 0; j < 4; j++) exp_b.push_back(8'hFF);
            d0 = done_cnt;
            pulse(0);
            wait_not_busy(20000, ok);
            check($sformatf("load%0d.finish", v), 32'(ok), 32'd1);
            repeat (200) @(negedge clock_i);
            check($sformatf("load%0d.nbytes", v), 32'(txb.size()), 32'(exp_b.size()));
            for (int j = 0; j < exp_b.size() && j < txb.size(); j++)
                check($sformatf("load%0d.byte%0d", v, j), 32'(txb[j]), 32'(exp_b[j]));
            check($sformatf("load%0d.err", v), 32'(err_o), 32'(vecs[v].exp_err));
            check($sformatf("load%0d.ready", v), 32'(ready_o), 32'(vecs[v].exp_ready));
            check($sformatf("load%0d.done", v), 32'(done_cnt - d0), vecs[v].exp_ready ? 32'd1 : 32'd0);
            check($sformatf("load%0d.prog_addr", v), 32'(prog_addr_o),
                  vecs[v].exp_ready ? 32'(vecs[v].len) - 32'd1 : 32'(vecs[v].exp_words));
            txb.delete();
        end

        // Step and full dump.
        pulse(1);
        wait_bytes(1, 2000, ok);
        check("step.cmd_seen", 32'(ok), 32'd1);
        if (ok) check("step.cmd_byte", 32'(txb[0]), 32'h01);
        txb.delete();
        repeat (20) @(negedge clock_i);
        check("step.busy", 32'(busy_o), 32'd1);
        we_base = we_cnt; bw0 = bad_words; d0 = done_cnt;
        for (int n = 0; n < N_WORDS; n++) send_word(32'hA500_0000 + 32'(n));
        repeat (20) @(negedge clock_i);
        check("dump.count", 32'(we_cnt - we_base), 32'(N_WORDS));
        check("dump.bad_words", 32'(bad_words - bw0), 32'd0);
        check("dump.last_addr", 32'(last_addr), 32'(N_WORDS - 1));
        wexp = 32'hA500_0000 + 32'(N_WORDS - 1);
        check("dump.last_data", last_data, wexp);
        check("dump.done", 32'(done_cnt - d0), 32'd1);
        check("dump.done_lat", 32'(last_done_cyc - last_we_cyc), 32'd1);
        check("dump.ready", 32'(ready_o), 32'd1);
        check("dump.busy", 32'(busy_o), 32'd0);

        // Continue returns to IDLE; a later step sends nothing.
        d0 = done_cnt;
        pulse(2);
        wait_bytes(1, 2000, ok);
        check("cont.cmd_seen", 32'(ok), 32'd1);
        if (ok) check("cont.cmd_byte", 32'(txb[0]), 32'h02);
        wait_not_busy(2000, ok);
        repeat (5) @(negedge clock_i);
        check("cont.done", 32'(done_cnt - d0), 32'd1);
        check("cont.ready", 32'(ready_o), 32'd0);
        txb.delete();
        pulse(1);
        repeat (300) @(negedge clock_i);
        check("cont.step_ignored", 32'(txb.size()), 32'd0);
        check("cont.busy", 32'(busy_o), 32'd0);

        // Reset after 100 dump bytes.
        load_spec_prog();
        pulse(1);
        wait_bytes(1, 2000, ok);
        check("rstdump.cmd_seen", 32'(ok), 32'd1);
        txb.delete();
        repeat (20) @(negedge clock_i);
        we_base = we_cnt;
        for (int n = 0; n < 25; n++) send_word(32'hA500_0000 + 32'(n));
        check("rstdump.count_before", 32'(we_cnt - we_base), 32'd25);
        reset_i = 1'b0;
        #1;
        check("rstdump.tx_o", 32'(tx_o), 32'd1);
        check("rstdump.flags", {27'd0, busy_o, ready_o, done_o, err_o, dump_we_o}, 32'd0);
        check("rstdump.addr", {dump_addr_o, 17'd0, prog_addr_o}, 32'd0);
        check("rstdump.data", dump_data_o, 32'd0);
        repeat (3) @(negedge clock_i);
        reset_i = 1'b1;
        w0 = we_cnt;
        send_word(32'hA500_0019); send_word(32'hA500_001A);
        repeat (20) @(negedge clock_i);
        check("rstdump.no_more_we", 32'(we_cnt - w0), 32'd0);
        check("rstdump.busy", 32'(busy_o), 32'd0);

`ifdef DEBUG_HOST_TIMEOUT_EN
        load_spec_prog();
        pulse(1);
        wait_bytes(1, 2000, ok);
        check("tmo.cmd_seen", 32'(ok), 32'd1);
        txb.delete();
        repeat (20) @(negedge clock_i);
        we_base = we_cnt; d0 = done_cnt;
        send_word(32'hA500_0000); send_word(32'hA500_0001);
        send_byte(8'h02); send_byte(8'h00);
        check("tmo.still_busy", 32'(busy_o), 32'd1);
        wait_not_busy(TMO + 1000, ok);
        check("tmo.finish", 32'(ok), 32'd1);
        repeat (3) @(negedge clock_i);
        check("tmo.we_count", 32'(we_cnt - we_base), 32'd2);
        check("tmo.err", 32'(err_o), 32'd1);
        check("tmo.done", 32'(done_cnt - d0), 32'd1);
        check("tmo.ready", 32'(ready_o), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        repeat (200000) @(posedge clock_i);
        $display("FAIL watchdog: got no finish expected finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end
endmodule

// File: doc/debug_host_link.md
# debug_host_link

Host-side counterpart of the MIPS debug unit's UART protocol, for a second FPGA or a system-level bench. It loads a program into the debug unit and then issues step or continue commands. After a step it captures the returned register and data-memory dump. Its `tx_o` drives the debug unit's UART receive line, and its `rx_i` listens to the debug unit's `debug_out`.

## Interface
- `NB_DATA`, 32, word width
- `N_BITS`, 8, UART byte width
- `N_BYTES`, 4, bytes per word
- `N_REGISTER`, 32, register words in a dump
- `N_MEMORY_DATA`, 127, memory words in a dump
- `NB_PADDR`, 7, program ROM address width
- `TIMEOUT_TICKS`, 32768, `tick` pulses allowed between dump bytes (timeout feature only)
- `clock_i` in 1: single system clock, rising edge
- `reset_i` in 1: asynchronous, active-low reset
- `tick` in 1: 16x baud oversample pulse, shared with the UART instances
- `rx_i` in 1: serial input from the debug unit
- `tx_o` out 1: serial output to the debug unit; reset value 1 (line idle)
- `load_i` in 1: pulse; start the program load
- `step_i` in 1: pulse; send step command (0x01), then capture the dump
- `cont_i` in 1: pulse; send continue command (0x02)
- `prog_len_i` in `NB_PADDR`: number of program words, valid range 1..127; sampled on `load_i`
- `prog_addr_o` out `NB_PADDR`: ROM address; reset 0
- `prog_data_i` in `NB_DATA`: ROM data, valid 1 cycle after `prog_addr_o`
- `dump_we_o` out 1: 1-cycle pulse per captured word; reset 0
- `dump_addr_o` out 8: word index 0..158 (0..31 registers, 32..158 memory); reset 0
- `dump_data_o` out `NB_DATA`: captured word; reset 0
- `busy_o` out 1: high in every state except IDLE and READY; reset 0
- `ready_o` out 1: program loaded, commands accepted; reset 0
- `done_o` out 1: 1-cycle pulse at the end of a load, command or dump; reset 0
- `err_o` out 1: sticky error flag, cleared by `load_i` or reset; reset 0

## Operation
- Instantiates `tx_uart` and `rx_uart`: 8N1, LSB-first bit order.
- Byte send:
  - Internal `tx_idle` register is set at reset and on each rising edge of `tx_done_tick`, and cleared by `tx_start`.
  - `tx_start` is a 1-cycle pulse, issued only when `tx_idle`=1.
- Word send: 4 bytes, least-significant byte first (bits [7:0], [15:8], [23:16], [31:24]).
- States and transitions:
  - IDLE: accepts `load_i` only; `step_i` and `cont_i` are ignored.
  - FETCH: drive `prog_addr_o`, wait 1 cycle, latch `prog_data_i`.
    - Latched word = 0xFFFFFFFF → set `err_o`, go to IDLE. That value is reserved as the terminator.
  - SEND_WORD: send the 4 bytes.
    - If more words remain, increment `prog_addr_o` and go to FETCH.
    - Otherwise go to SEND_TERM.
  - SEND_TERM: send 0xFF ×4, pulse `done_o`, go to READY.
  - READY: `ready_o`=1. Priority when requests coincide: `load_i` > `step_i` > `cont_i`.
    - `load_i` → clear `err_o`, restart the load.
    - `step_i` → SEND_MODE with byte 0x01.
    - `cont_i` → SEND_MODE with byte 0x02.
  - SEND_MODE: send the mode byte.
    - Step → RX_DUMP, with the word index and byte counter cleared.
    - Continue → pulse `done_o`, go to IDLE. The target is now free-running and the program must be reloaded before the next command.
  - RX_DUMP: each `rx_done_tick` places the byte at lane [8k+7:8k], k = byte counter.
    - After the 4th byte, pulse `dump_we_o` with the assembled word and the current `dump_addr_o`, then increment the index.
    - After index 158 is written, pulse `done_o` and go to READY.
- `load_i`, `step_i` and `cont_i` arriving in any busy state are ignored.
- Bytes received outside RX_DUMP are discarded.

## Timing
- ROM read latency is exactly 1 cycle.
- Back-to-back bytes: the next `tx_start` is issued in the cycle after `tx_idle` returns high. There is no added gap.
- `dump_we_o` asserts 1 cycle after the `rx_done_tick` of the 4th byte. `dump_addr_o` and `dump_data_o` are stable during that pulse.
- `done_o` at the end of a dump asserts 1 cycle after the final `dump_we_o`.
- Asynchronous reset mid-operation:
  - All outputs return immediately to their reset values.
  - The UART instances are reset and `tx_o` is forced high.
  - Any partial word is discarded.
- A dump totals 159 words (636 bytes).

## Configuration
- `DEBUG_HOST_TIMEOUT_EN` defined:
  - In RX_DUMP, a counter counts `tick` pulses and clears on every received byte.
  - On reaching `TIMEOUT_TICKS`: set `err_o`, pulse `done_o`, go to IDLE.
- Not defined: RX_DUMP waits indefinitely and there is no counter logic.

## Test plan
- Load, 3 words: `prog_len_i`=3, ROM = 0x20010005, 0x20020003, 0x00221820, then `load_i`.
  - `tx_o` carries bytes 05 00 01 20 03 00 02 20 20 18 22 00 FF FF FF FF.
  - Then `done_o` pulses and `ready_o`=1.
- Reserved word: ROM word 1 = 0xFFFFFFFF.
  - Only word 0's 4 bytes are sent.
  - Then `err_o`=1 and the block is in IDLE.
- Step: `step_i` in READY.
  - Byte 0x01 is sent.
  - Model then sends 636 bytes, word n = 0xA5000000+n.
  - 159 `dump_we_o` pulses occur, index 158 carries data 0xA500009E, then `done_o` pulses and the block returns to READY.
- Continue: `cont_i` in READY.
  - Byte 0x02 is sent, `done_o` pulses, the block goes to IDLE.
  - A following `step_i` sends nothing.
- Reset mid-dump: assert `reset_i` low after 100 dump bytes.
  - `tx_o`=1, all outputs are at reset values, and no further `dump_we_o` pulses occur.
- Timeout (`DEBUG_HOST_TIMEOUT_EN`): model stops after 10 dump bytes.
  - 2 `dump_we_o` pulses occur.
  - After `TIMEOUT_TICKS` ticks, `err_o`=1, `done_o` pulses, and the block is in IDLE.
